// File: rtl/cursor_ctrl.sv
// cursor_ctrl: turns raw direction/press buttons into a registered cursor
// position, one-hot row/column selects and a single-cycle toggle strobe.
// Buttons and setup pass through 2-flop synchronizers; a held direction
// steps once, then auto-repeats after REPEAT_DELAY cycles every REPEAT_RATE.
// Optional feature: define CURSOR_WRAP_EN to wrap the cursor at grid edges;
// left undefined, the cursor saturates at the edges.
module cursor_ctrl #(
   parameter int ROWS         = 16,
   parameter int COLS         = 16,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 6250000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    setup,
   input  logic                    up,
   input  logic                    down,
   input  logic                    left,
   input  logic                    right,
   input  logic                    press,
   output logic [$clog2(ROWS)-1:0] cursor_row,
   output logic [$clog2(COLS)-1:0] cursor_col,
   output logic [ROWS-1:0]         row_sel,
   output logic [COLS-1:0]         col_sel,
   output logic                    toggle,
   output logic [1:0]              dbg_state
);

   localparam int RW      = $clog2(ROWS);
   localparam int CLW     = $clog2(COLS);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW      = $clog2(RPT_MAX);

   localparam logic [CW-1:0]   DELAY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0]   RATE_LAST  = CW'(REPEAT_RATE - 1);
   localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
   localparam logic [CLW-1:0]  COL_LAST   = CLW'(COLS - 1);
   localparam logic [ROWS-1:0] ROW_ONE    = ROWS'(1);
   localparam logic [COLS-1:0] COL_ONE    = COLS'(1);

`ifdef CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [5:0]      sync1_q, sync2_q;   // {setup, press, up, down, left, right}
   logic            press_prev_q;
   logic [RW-1:0]   row_q, row_d;
   logic [CLW-1:0]  col_q, col_d;
   logic [ROWS-1:0] row_sel_q, row_sel_d;
   logic [COLS-1:0] col_sel_q, col_sel_d;
   logic            toggle_q, toggle_d;

   logic setup_s, press_s, up_s, down_s, left_s, right_s;
   logic any_dir, press_edge, step;

   assign {setup_s, press_s, up_s, down_s, left_s, right_s} = sync2_q;
   assign any_dir    = up_s | down_s | left_s | right_s;
   assign press_edge = press_s & ~press_prev_q;

   // State register: synchronizers, edge flop, FSM, counter, cursor and outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         press_prev_q <= 1'b0;
         state_q      <= IDLE;
         cnt_q        <= '0;
         row_q        <= '0;
         col_q        <= '0;
         row_sel_q    <= '0;
         col_sel_q    <= '0;
         toggle_q     <= 1'b0;
      end else begin
         sync1_q      <= {setup, press, up, down, left, right};
         sync2_q      <= sync1_q;
         press_prev_q <= press_s;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_q        <= row_d;
         col_q        <= col_d;
         row_sel_q    <= row_sel_d;
         col_sel_q    <= col_sel_d;
         toggle_q     <= toggle_d;
      end
   end

   // Next state: move FSM, press/step arbitration, cursor update and select decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      row_d    = row_q;
      col_d    = col_q;
      toggle_d = 1'b0;
      step     = 1'b0;

      if (!setup_s) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_dir) begin
                  step    = 1'b1;
                  cnt_d   = '0;
                  state_d = DELAY;
               end
            end
            DELAY: begin
               if (!any_dir) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DELAY_LAST) begin
                  step    = 1'b1;
                  cnt_d   = '0;
                  state_d = REPEAT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            REPEAT: begin
               if (!any_dir) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == RATE_LAST) begin
                  step  = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase

         // A toggle wins over a step so the strobe sees a stable select;
         // freezing FSM and counter retries the step next cycle.
         if (press_edge) begin
            toggle_d = 1'b1;
            if (step) begin
               step    = 1'b0;
               state_d = state_q;
               cnt_d   = cnt_q;
            end
         end
      end

      if (step) begin
         if (up_s) begin
            if (row_q != '0)      row_d = row_q - RW'(1);
            else if (WRAP)        row_d = ROW_LAST;
         end else if (down_s) begin
            if (row_q != ROW_LAST) row_d = row_q + RW'(1);
            else if (WRAP)         row_d = '0;
         end else if (left_s) begin
            if (col_q != '0)      col_d = col_q - CLW'(1);
            else if (WRAP)        col_d = COL_LAST;
         end else begin
            if (col_q != COL_LAST) col_d = col_q + CLW'(1);
            else if (WRAP)         col_d = '0;
         end
      end

      row_sel_d = setup_s ? (ROW_ONE << row_d) : '0;
      col_sel_d = setup_s ? (COL_ONE << col_d) : '0;
   end

   assign cursor_row = row_q;
   assign cursor_col = col_q;
   assign row_sel    = row_sel_q;
   assign col_sel    = col_sel_q;
   assign toggle     = toggle_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed stimulus for cursor_ctrl with ROWS=COLS=16,
// REPEAT_DELAY=8, REPEAT_RATE=4, checked every cycle against a timing
// model of the cursor plus hand-computed literal expectations.
module tb_cursor_ctrl;

   localparam int ROWS = 16;
   localparam int COLS = 16;
   localparam int RD   = 8;
   localparam int RR   = 4;

`ifdef CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        setup, up, down, left, right, press;
   logic [3:0]  cursor_row, cursor_col;
   logic [15:0] row_sel, col_sel;
   logic        toggle;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   cursor_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .reset(reset), .setup(setup),
      .up(up), .down(down), .left(left), .right(right), .press(press),
      .cursor_row(cursor_row), .cursor_col(cursor_col),
      .row_sel(row_sel), .col_sel(col_sel), .toggle(toggle),
      .dbg_state(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The cursor steps when a hold begins, then after RD cycles, then every RR.
   // A press edge landing on a step cycle pushes that step one cycle later.
   function automatic int move(input int pos, input int delta, input int n);
      int p;
      p = pos + delta;
      if (p < 0)       p = WRAP ? n - 1 : 0;
      else if (p >= n) p = WRAP ? 0 : n - 1;
      return p;
   endfunction

   int          m_row, m_col, m_cyc, m_due;
   bit          m_hold, m_first, m_prev, m_tog;
   logic [15:0] m_rsel, m_csel;
   logic [5:0]  m_r1, m_r2, m_s;   // {setup, press, up, down, left, right}
   bit          m_any, m_edge, m_step;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_row = 0; m_col = 0; m_cyc = 0; m_due = 0;
         m_hold = 0; m_first = 0; m_prev = 0; m_tog = 0;
         m_rsel = '0; m_csel = '0; m_r1 = '0; m_r2 = '0;
      end else begin
         m_s  = m_r2;
         m_r2 = m_r1;
         m_r1 = {setup, press, up, down, left, right};
         m_cyc++;
         m_tog = 0;
         if (m_s[5]) begin
            m_any  = |m_s[3:0];
            m_edge = m_s[4] && !m_prev;
            if (!m_any) m_hold = 0;
            else if (!m_hold) begin
               m_hold = 1; m_due = m_cyc; m_first = 1;
            end
            m_step = m_hold && (m_cyc >= m_due);
            if (m_edge) begin
               m_tog = 1;
               if (m_step) begin
                  m_step = 0;
                  m_due  = m_cyc + 1;
               end
            end
            if (m_step) begin
               if (m_s[3])      m_row = move(m_row, -1, ROWS);
               else if (m_s[2]) m_row = move(m_row,  1, ROWS);
               else if (m_s[1]) m_col = move(m_col, -1, COLS);
               else             m_col = move(m_col,  1, COLS);
               m_due   = m_cyc + (m_first ? RD : RR);
               m_first = 0;
            end
            m_rsel = 16'h1 << m_row;
            m_csel = 16'h1 << m_col;
         end else begin
            m_hold = 0;
            m_rsel = '0;
            m_csel = '0;
         end
         m_prev = m_s[4];
      end
   end

   // ---------------- per-cycle compare + toggle monitor ----------------
   int          tog_cnt = 0;
   logic [15:0] tog_rsel, tog_csel;
   logic [3:0]  after_col;
   bit          tog_prev = 0;

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("cyc_row",    cursor_row, m_row);
         check("cyc_col",    cursor_col, m_col);
         check("cyc_rowsel", row_sel,    m_rsel);
         check("cyc_colsel", col_sel,    m_csel);
         check("cyc_toggle", toggle,     m_tog);
      end
      if (tog_prev) after_col = cursor_col;
      if (toggle === 1'b1) begin
         tog_cnt++;
         tog_rsel = row_sel;
         tog_csel = col_sel;
      end
      tog_prev = (toggle === 1'b1);
   end

   // ---------------- driver tasks ----------------
   task automatic set_dir(input int d, input logic v);
      case (d)
         0: up    = v;
         1: down  = v;
         2: left  = v;
         default: right = v;
      endcase
   endtask

   task automatic hold(input int d, input int n);
      @(negedge clk);
      set_dir(d, 1'b1);
      repeat (n) @(negedge clk);
      set_dir(d, 1'b0);
   endtask

   task automatic pulse(input int d, input int times);
      for (int i = 0; i < times; i++) begin
         hold(d, 1);
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   int base;
   int er, ec;

   initial begin
      reset = 1'b0; setup = 1'b1;
      up = 0; down = 0; left = 0; right = 0; press = 0;
      @(posedge clk); #3;
      chk_en = 1'b1;
      idle(2);
      check("rst_row",    cursor_row, 0);
      check("rst_rowsel", row_sel,    16'h0000);
      check("rst_toggle", toggle,     0);
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      check("lat_rowsel_early", row_sel, 16'h0000);
      @(posedge clk); #2;
      check("lat_rowsel", row_sel, 16'h0001);
      check("lat_colsel", col_sel, 16'h0001);
      check("lat_row",    cursor_row, 0);

      // Short right pulse: exactly one step, FSM returns to idle
      hold(3, 2);
      idle(6);
      check("pulse_col",    cursor_col, 1);
      check("pulse_colsel", col_sel,    16'h0002);
      check("pulse_idle",   dbg_state,  0);

      // 27-cycle hold of down: steps at 0, 8, 12, 16, 20, 24
      hold(1, 27);
      idle(8);
      check("repeat_row", cursor_row, 6);

      // Walk to (3,5) and hold press for 10 cycles
      pulse(0, 3);
      pulse(3, 4);
      check("pos_rowsel", row_sel, 16'h0008);
      check("pos_colsel", col_sel, 16'h0020);
      base = tog_cnt;
      @(negedge clk); press = 1'b1;
      idle(10);
      press = 1'b0;
      idle(5);
      check("press_count",  tog_cnt - base, 1);
      check("press_rowsel", tog_rsel, 16'h0008);
      check("press_colsel", tog_csel, 16'h0020);

      // Press edge on the same cycle as the first repeat step (hold index 12)
      base = tog_cnt;
      @(negedge clk); right = 1'b1;
      idle(12);
      press = 1'b1;
      idle(12);
      right = 1'b0; press = 1'b0;
      idle(6);
      check("coll_count",     tog_cnt - base, 1);
      check("coll_tog_col",   tog_csel, 16'h0080);
      check("coll_tog_row",   tog_rsel, 16'h0008);
      check("coll_after_col", after_col, 8);
      check("coll_final_col", cursor_col, 10);

      // Back to the origin, then push past the top and left edges
      pulse(0, 3);
      pulse(2, 10);
      check("origin_row", cursor_row, 0);
      check("origin_col", cursor_col, 0);
      er = WRAP ? 15 : 0;
      ec = WRAP ? 15 : 0;
      pulse(0, 1);
      check("edge_row", cursor_row, er);
      pulse(2, 1);
      check("edge_col", cursor_col, ec);

      // Drop setup: selects clear, press and directions ignored, cursor kept
      @(negedge clk); setup = 1'b0;
      idle(4);
      check("nosetup_rowsel", row_sel, 16'h0000);
      check("nosetup_colsel", col_sel, 16'h0000);
      base = tog_cnt;
      @(negedge clk); press = 1'b1;
      idle(2);
      press = 1'b0;
      pulse(1, 1);
      idle(3);
      check("nosetup_toggle", tog_cnt - base, 0);
      check("nosetup_row",    cursor_row, er);
      check("nosetup_col",    cursor_col, ec);

      // Press held across setup rising edge: no toggle until a fresh edge
      @(negedge clk); press = 1'b1;
      idle(3);
      setup = 1'b1;
      idle(6);
      check("setup_held_press", tog_cnt - base, 0);
      check("setup_back_rowsel", row_sel, 16'h1 << er);
      press = 1'b0;
      idle(3);
      press = 1'b1;
      idle(2);
      press = 1'b0;
      idle(5);
      check("fresh_press", tog_cnt - base, 1);

      // Reset in the middle of a hold, direction still held after release
      @(negedge clk); down = 1'b1;
      idle(5);
      reset = 1'b0;
      idle(1);
      check("midrst_row",    cursor_row, 0);
      check("midrst_rowsel", row_sel,    16'h0000);
      reset = 1'b1;
      idle(4);
      check("after_rst_row",    cursor_row, 1);
      check("after_rst_rowsel", row_sel,    16'h0002);
      check("after_rst_col",    cursor_col, 0);
      down = 1'b0;
      idle(5);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
